// File: rtl/qspi_flash_op_sequencer_if.sv
// Purpose: bundles the operation request port and the engine transaction port of the sequencer.
// Latency: wires only, no storage.
// Backpressure: op side via op_ready_o; engine side holds eng_req_o until eng_ack_i.
interface qspi_flash_op_sequencer_if #(
  parameter int AW = 24
);
  // Operation request side (register block -> sequencer)
  logic          op_valid_i;
  logic          op_ready_o;
  logic [1:0]    op_type_i;
  logic [AW-1:0] op_addr_i;
  logic [8:0]    op_len_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [7:0]    fsr_o;

  // Engine transaction side (sequencer -> QSPI transaction engine)
  logic          eng_req_o;
  logic [7:0]    eng_cmd_o;
  logic [AW-1:0] eng_addr_o;
  logic          eng_has_addr_o;
  logic [8:0]    eng_len_o;
  logic          eng_rd_o;
  logic          eng_ack_i;
  logic          eng_done_i;
  logic [7:0]    eng_rdata_i;

  // The sequencer itself: drives status and engine requests
  modport master (
    input  op_valid_i, op_type_i, op_addr_i, op_len_i,
    output op_ready_o, busy_o, done_o, err_o, fsr_o,
    output eng_req_o, eng_cmd_o, eng_addr_o, eng_has_addr_o, eng_len_o, eng_rd_o,
    input  eng_ack_i, eng_done_i, eng_rdata_i
  );

  // The surroundings: register block plus transaction engine
  modport slave (
    output op_valid_i, op_type_i, op_addr_i, op_len_i,
    input  op_ready_o, busy_o, done_o, err_o, fsr_o,
    input  eng_req_o, eng_cmd_o, eng_addr_o, eng_has_addr_o, eng_len_o, eng_rd_o,
    output eng_ack_i, eng_done_i, eng_rdata_i
  );
endinterface

// File: rtl/qspi_flash_op_sequencer.sv
// Purpose: expands one flash program/erase/config op into WREN, op and RFSR-poll engine transactions.
// Latency: first engine request one cycle after accept; done/err one cycle after the final poll completes.
// Backpressure: op_ready_o only in IDLE; each engine request is held stable until eng_ack_i.
module qspi_flash_op_sequencer #(
  parameter int POLL_LIMIT = 65535,
  parameter int AW         = 24
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  qspi_flash_op_sequencer_if.master bus
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] POLL_MAX = CW'(POLL_LIMIT);

  localparam logic [7:0] CMD_WREN   = 8'h06;
  localparam logic [7:0] CMD_PP     = 8'h02;
  localparam logic [7:0] CMD_SE     = 8'hD8;
  localparam logic [7:0] CMD_BE     = 8'hC7;
  localparam logic [7:0] CMD_WRVECR = 8'h61;
  localparam logic [7:0] CMD_RFSR   = 8'h70;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN_REQ,
    S_WREN_WAIT,
    S_OP_REQ,
    S_OP_WAIT,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [1:0]      op_type_q;
  logic [AW-1:0]   op_addr_q;
  logic [8:0]      op_len_q;
  logic [CW-1:0]   poll_cnt_q;

  logic            eng_req_q;
  logic [7:0]      eng_cmd_q;
  logic [AW-1:0]   eng_addr_q;
  logic            eng_has_addr_q;
  logic [8:0]      eng_len_q;
  logic            eng_rd_q;
  logic            done_q;
  logic            err_q;
  logic            busy_q;
  logic [7:0]      fsr_q;

  logic            op_legal;
  logic [CW-1:0]   poll_cnt_d;
  logic [7:0]      op_cmd_d;
  logic            op_has_addr_d;
  logic [AW-1:0]   op_addr_d;
  logic [8:0]      op_len_d;

  // Decode request legality, the next poll count and the fields of the main operation transaction
  always_comb begin
    op_legal      = (bus.op_type_i != 2'd0) || ((bus.op_len_i != 9'd0) && (bus.op_len_i <= 9'd256));
    poll_cnt_d    = poll_cnt_q + 1'b1;
    op_cmd_d      = CMD_PP;
    op_has_addr_d = 1'b1;
    op_len_d      = op_len_q;
    case (op_type_q)
      2'd1: begin
        op_cmd_d = CMD_SE;
        op_len_d = 9'd0;
      end
      2'd2: begin
        op_cmd_d      = CMD_BE;
        op_has_addr_d = 1'b0;
        op_len_d      = 9'd0;
      end
      2'd3: begin
        op_cmd_d      = CMD_WRVECR;
        op_has_addr_d = 1'b0;
        op_len_d      = 9'd1;
      end
      default: ;
    endcase
    op_addr_d = op_has_addr_d ? op_addr_q : '0;
  end

  // Sequencer FSM with registered engine request, status pulses and captured flag status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      op_type_q      <= 2'd0;
      op_addr_q      <= '0;
      op_len_q       <= 9'd0;
      poll_cnt_q     <= '0;
      eng_req_q      <= 1'b0;
      eng_cmd_q      <= 8'h00;
      eng_addr_q     <= '0;
      eng_has_addr_q <= 1'b0;
      eng_len_q      <= 9'd0;
      eng_rd_q       <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      fsr_q          <= 8'h00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid_i) begin
            if (op_legal) begin
              op_type_q      <= bus.op_type_i;
              op_addr_q      <= bus.op_addr_i;
              op_len_q       <= bus.op_len_i;
              poll_cnt_q     <= '0;
              state_q        <= S_WREN_REQ;
              busy_q         <= 1'b1;
              eng_req_q      <= 1'b1;
              eng_cmd_q      <= CMD_WREN;
              eng_addr_q     <= '0;
              eng_has_addr_q <= 1'b0;
              eng_len_q      <= 9'd0;
              eng_rd_q       <= 1'b0;
            end else begin
              // Bad page-program length: flag it and never touch the engine
              err_q <= 1'b1;
            end
          end
        end
        S_WREN_REQ: begin
          if (bus.eng_ack_i) begin
            eng_req_q <= 1'b0;
            state_q   <= S_WREN_WAIT;
          end
        end
        S_WREN_WAIT: begin
          if (bus.eng_done_i) begin
            state_q        <= S_OP_REQ;
            eng_req_q      <= 1'b1;
            eng_cmd_q      <= op_cmd_d;
            eng_addr_q     <= op_addr_d;
            eng_has_addr_q <= op_has_addr_d;
            eng_len_q      <= op_len_d;
            eng_rd_q       <= 1'b0;
          end
        end
        S_OP_REQ: begin
          if (bus.eng_ack_i) begin
            eng_req_q <= 1'b0;
            state_q   <= S_OP_WAIT;
          end
        end
        S_OP_WAIT: begin
          if (bus.eng_done_i) begin
            state_q        <= S_POLL_REQ;
            eng_req_q      <= 1'b1;
            eng_cmd_q      <= CMD_RFSR;
            eng_addr_q     <= '0;
            eng_has_addr_q <= 1'b0;
            eng_len_q      <= 9'd1;
            eng_rd_q       <= 1'b1;
          end
        end
        S_POLL_REQ: begin
          if (bus.eng_ack_i) begin
            eng_req_q <= 1'b0;
            state_q   <= S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (bus.eng_done_i) begin
            fsr_q <= bus.eng_rdata_i;
            if (bus.eng_rdata_i[7]) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (poll_cnt_d == POLL_MAX) begin
              // Flash never reported ready: give up straight back to IDLE
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              // RFSR fields are still in place from the previous poll
              poll_cnt_q <= poll_cnt_d;
              state_q    <= S_POLL_REQ;
              eng_req_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          eng_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready_o     = (state_q == S_IDLE);
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.err_o          = err_q;
  assign bus.fsr_o          = fsr_q;
  assign bus.eng_req_o      = eng_req_q;
  assign bus.eng_cmd_o      = eng_cmd_q;
  assign bus.eng_addr_o     = eng_addr_q;
  assign bus.eng_has_addr_o = eng_has_addr_q;
  assign bus.eng_len_o      = eng_len_q;
  assign bus.eng_rd_o       = eng_rd_q;

endmodule

// File: tb/tb_qspi_flash_op_sequencer.sv
// Purpose: directed bench with a behavioural flash engine and a transaction-list model of each operation.
// Latency: checks accept-to-request, ack/done hand-off and completion timing in cycles.
// Backpressure: engine model delays ack and done by programmable cycle counts.
module tb_qspi_flash_op_sequencer;

  localparam int PL = 4;

  typedef struct packed {
    logic [7:0]  cmd;
    logic        has_addr;
    logic [23:0] addr;
    logic [8:0]  len;
    logic        rd;
  } txn_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   fails;

  qspi_flash_op_sequencer_if #(.AW(24)) bus ();

  qspi_flash_op_sequencer #(.POLL_LIMIT(PL), .AW(24)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Expected transaction list (written by main, consumed by engine)
  txn_t       exp_arr[256];
  int         exp_wr, exp_rd;
  // RFSR responses (written by main, consumed by engine)
  logic [7:0] rsp_arr[256];
  int         rsp_wr, rsp_rd;
  // Engine configuration and observation
  int         ack_delay, done_delay;
  int         req_total, acked_total, last_eng_done_cyc;
  int         req_cyc[256];
  int         spur_idle_req, spur_idle_seen, spur_wren_req, spur_wren_seen;
  // Output monitor observation
  int         done_total, err_total, last_done_o_cyc, last_err_cyc, rdy_rise_cyc, ready_low_total;
  logic [7:0] model_fsr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic [7:0] c, input logic h, input logic [23:0] a,
                              input logic [8:0] l, input logic r);
    txn_t t;
    t.cmd = c; t.has_addr = h; t.addr = h ? a : 24'h0; t.len = l; t.rd = r;
    return t;
  endfunction

  function automatic txn_t sample();
    return mk(bus.eng_cmd_o, bus.eng_has_addr_o, bus.eng_addr_o, bus.eng_len_o, bus.eng_rd_o);
  endfunction

  function automatic logic [63:0] outs();
    return {8'h0, bus.op_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.fsr_o, bus.eng_req_o,
            bus.eng_cmd_o, bus.eng_addr_o, bus.eng_has_addr_o, bus.eng_len_o, bus.eng_rd_o};
  endfunction

  // Behavioural engine: acks after ack_delay, completes after done_delay, checks each request
  initial begin : engine
    int   ph, wcnt, run;
    bit   just_acked, just_done;
    txn_t cur;
    ph = 0; wcnt = 0; run = 0; just_acked = 0; just_done = 0; cur = '0;
    exp_rd = 0; rsp_rd = 0; req_total = 0; acked_total = 0; last_eng_done_cyc = 0;
    spur_idle_seen = 0; spur_wren_seen = 0;
    bus.eng_ack_i = 1'b0; bus.eng_done_i = 1'b0; bus.eng_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      bus.eng_ack_i   = 1'b0;
      bus.eng_done_i  = 1'b0;
      bus.eng_rdata_i = 8'hA5;
      if (!rst_n) begin
        ph = 0; just_acked = 0; just_done = 0;
      end else begin
        if (spur_idle_req != spur_idle_seen) begin
          spur_idle_seen  = spur_idle_req;
          bus.eng_done_i  = 1'b1;
          bus.eng_rdata_i = 8'h5A;
        end
        case (ph)
          0: begin
            if (just_done) begin
              just_done = 0;
              if (exp_rd < exp_wr) chk("next_req_after_done", bus.eng_req_o, 1);
            end
            if (bus.eng_req_o) begin
              cur = sample();
              req_cyc[req_total] = cyc;
              req_total++;
              if (exp_rd < exp_wr) begin
                chk("txn_fields", cur, exp_arr[exp_rd]);
                exp_rd++;
              end else begin
                chk("unexpected_req", 1, 0);
              end
              if (ack_delay == 0) begin
                bus.eng_ack_i = 1'b1; acked_total++;
                ph = 2; just_acked = 1; run = done_delay;
              end else begin
                wcnt = ack_delay; ph = 1;
              end
            end
          end
          1: begin
            chk("req_stable", {bus.eng_req_o, sample()}, {1'b1, cur});
            wcnt--;
            if (spur_wren_req != spur_wren_seen && cur.cmd == 8'h06 && wcnt == 2) begin
              spur_wren_seen  = spur_wren_req;
              bus.eng_done_i  = 1'b1;
              bus.eng_rdata_i = 8'hFF;
            end
            if (wcnt == 0) begin
              bus.eng_ack_i = 1'b1; acked_total++;
              ph = 2; just_acked = 1; run = done_delay;
            end
          end
          default: begin
            if (just_acked) begin
              just_acked = 0;
              chk("req_drop_after_ack", bus.eng_req_o, 0);
            end
            if (run == 0) begin
              bus.eng_done_i = 1'b1;
              if (cur.cmd == 8'h70) begin
                if (rsp_rd < rsp_wr) begin
                  bus.eng_rdata_i = rsp_arr[rsp_rd];
                  rsp_rd++;
                end else begin
                  bus.eng_rdata_i = 8'h00;
                end
              end
              last_eng_done_cyc = cyc;
              ph = 0; just_done = 1;
            end else begin
              run--;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle compare of status outputs against the operation-level rules
  initial begin : monitor
    bit prev_rdy, prev_done;
    prev_rdy = 1; prev_done = 0;
    done_total = 0; err_total = 0; last_done_o_cyc = 0; last_err_cyc = 0;
    rdy_rise_cyc = 0; ready_low_total = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 1; prev_done = 0;
      end else begin
        chk("busy_vs_ready", bus.busy_o, !bus.op_ready_o);
        chk("done_err_exclusive", bus.done_o && bus.err_o, 0);
        if (bus.done_o) begin
          done_total++; last_done_o_cyc = cyc;
          chk("done_single_cycle", prev_done, 0);
        end
        if (bus.err_o) begin
          err_total++; last_err_cyc = cyc;
        end
        if (bus.op_ready_o && !prev_rdy) rdy_rise_cyc = cyc;
        if (!bus.op_ready_o) ready_low_total++;
        prev_rdy  = bus.op_ready_o;
        prev_done = bus.done_o;
      end
    end
  end

  task automatic push(input txn_t t);
    exp_arr[exp_wr] = t;
    exp_wr++;
  endtask

  task automatic give(input logic [7:0] r);
    rsp_arr[rsp_wr] = r;
    rsp_wr++;
  endtask

  task automatic submit(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.op_ready_o && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.op_ready_o) chk("ready_wait_timeout", 0, 1);
    bus.op_valid_i = 1'b1;
    bus.op_type_i  = t;
    bus.op_addr_i  = a;
    bus.op_len_i   = l;
    acc = cyc;
    @(negedge clk);
    bus.op_valid_i = 1'b0;
  endtask

  // Plan an operation from the flash protocol rules, run it and compare the outcome
  task automatic run_op(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l,
                        input int ackd, input int doned,
                        input int lit_n, input logic lit_err, input logic [7:0] lit_fsr);
    int         n, d0, e0, r0, rl0, acc, k;
    logic       pe, pd;
    logic [7:0] pf, r;
    bit         reject;
    ack_delay  = ackd;
    done_delay = doned;
    reject = (t == 2'd0) && (l == 9'd0 || l > 9'd256);
    n = 0; pe = 0; pd = 0; pf = model_fsr;
    if (reject) begin
      pe = 1;
    end else begin
      push(mk(8'h06, 0, 24'h0, 9'd0, 0)); n++;
      case (t)
        2'd0:    push(mk(8'h02, 1, a, l, 0));
        2'd1:    push(mk(8'hD8, 1, a, 9'd0, 0));
        2'd2:    push(mk(8'hC7, 0, 24'h0, 9'd0, 0));
        default: push(mk(8'h61, 0, 24'h0, 9'd1, 0));
      endcase
      n++;
      for (int i = 0; i < PL; i++) begin
        r = (rsp_rd + i < rsp_wr) ? rsp_arr[rsp_rd + i] : 8'h00;
        push(mk(8'h70, 0, 24'h0, 9'd1, 1)); n++;
        pf = r;
        if (r[7]) begin
          pd = 1;
          break;
        end
        if (i == PL - 1) pe = 1;
      end
    end
    chk("model_ntxn", n, lit_n);
    chk("model_err", pe, lit_err);
    chk("model_fsr", pf, lit_fsr);

    d0 = done_total; e0 = err_total; r0 = req_total; rl0 = ready_low_total;
    submit(t, a, l, acc);
    repeat (2) @(negedge clk);
    k = 0;
    while (!bus.op_ready_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.op_ready_o) chk("op_finish_timeout", 0, 1);
    repeat (3) @(negedge clk);

    chk("done_pulses", done_total - d0, pd);
    chk("err_pulses", err_total - e0, pe);
    chk("txns_issued", exp_rd, exp_wr);
    chk("fsr", bus.fsr_o, pf);
    model_fsr = pf;
    if (reject) begin
      chk("reject_err_cycle", last_err_cyc, acc + 1);
      chk("reject_no_req", req_total - r0, 0);
      chk("reject_ready_held", ready_low_total - rl0, 0);
    end else begin
      chk("req_count", req_total - r0, n);
      chk("first_req_cycle", req_cyc[r0], acc + 1);
      if (pd) begin
        chk("done_cycle", last_done_o_cyc, last_eng_done_cyc + 1);
        chk("ready_cycle_done", rdy_rise_cyc, last_eng_done_cyc + 2);
      end else begin
        chk("timeout_err_cycle", last_err_cyc, last_eng_done_cyc + 1);
        chk("ready_cycle_err", rdy_rise_cyc, last_eng_done_cyc + 1);
      end
    end
  endtask

  task automatic spur_idle_test();
    logic [63:0] snap;
    repeat (2) @(negedge clk);
    snap = outs();
    spur_idle_req++;
    repeat (4) begin
      @(negedge clk);
      chk("spurious_done_idle", outs(), snap);
    end
  endtask

  task automatic wait_req_total(input int target);
    int k;
    k = 0;
    while (req_total < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (req_total < target) chk("req_wait_timeout", 0, 1);
  endtask

  initial begin : main
    int acc, k, a0;
    vectors = 0; fails = 0;
    exp_wr = 0; rsp_wr = 0; ack_delay = 0; done_delay = 0;
    spur_idle_req = 0; spur_wren_req = 0; model_fsr = 8'h00;
    rst_n = 1'b0;
    bus.op_valid_i = 1'b0; bus.op_type_i = 2'd0; bus.op_addr_i = 24'h0; bus.op_len_i = 9'd0;

    repeat (3) @(negedge clk);
    chk("rst_eng_req", bus.eng_req_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_fsr", bus.fsr_o, 0);
    chk("rst_cmd", bus.eng_cmd_o, 0);
    chk("rst_addr", bus.eng_addr_o, 0);
    chk("rst_len", bus.eng_len_o, 0);
    chk("rst_has_addr", bus.eng_has_addr_o, 0);
    chk("rst_rd", bus.eng_rd_o, 0);
    chk("rst_op_ready", bus.op_ready_o, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Page program, full page, ready on the third poll
    give(8'h00); give(8'h00); give(8'h80);
    run_op(2'd0, 24'h012340, 9'd256, 0, 1, 5, 0, 8'h80);

    // Bulk erase with slow acks and a stray done while WREN is waiting for ack
    give(8'h80);
    spur_wren_req++;
    run_op(2'd2, 24'h777777, 9'd0, 5, 2, 3, 0, 8'h80);

    // Illegal page-program lengths
    run_op(2'd0, 24'h000010, 9'd0, 0, 0, 0, 1, 8'h80);
    run_op(2'd0, 24'h000010, 9'd300, 0, 0, 0, 1, 8'h80);
    run_op(2'd0, 24'h000010, 9'd257, 0, 0, 0, 1, 8'h80);

    // Minimum legal length at the top address, second poll ready with extra flag bits
    give(8'h00); give(8'h81);
    run_op(2'd0, 24'hFFFFFF, 9'd1, 1, 0, 4, 0, 8'h81);

    // Sector erase; 0x7F has every bit but the ready bit
    give(8'h7F); give(8'h80);
    run_op(2'd1, 24'hABCDEF, 9'd0, 0, 3, 4, 0, 8'h80);

    spur_idle_test();

    // Reset while a WREN request is being held
    ack_delay = 20; done_delay = 0;
    a0 = req_total;
    push(mk(8'h06, 0, 24'h0, 9'd0, 0));
    push(mk(8'hC7, 0, 24'h0, 9'd0, 0));
    submit(2'd2, 24'h0, 9'd0, acc);
    wait_req_total(a0 + 1);
    repeat (2) @(negedge clk);
    chk("pre_reset_req_held", bus.eng_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req_drop", bus.eng_req_o, 0);
    chk("async_rst_ready", bus.op_ready_o, 1);
    repeat (2) @(negedge clk);
    exp_wr = exp_rd;
    rst_n = 1'b1;
    model_fsr = 8'h00;
    @(negedge clk);

    // Reset during the sector-erase wait
    ack_delay = 0; done_delay = 40;
    a0 = acked_total;
    push(mk(8'h06, 0, 24'h0, 9'd0, 0));
    push(mk(8'hD8, 1, 24'h040000, 9'd0, 0));
    submit(2'd1, 24'h040000, 9'd0, acc);
    k = 0;
    while (acked_total < a0 + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (acked_total < a0 + 2) chk("se_ack_wait_timeout", 0, 1);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req_low", bus.eng_req_o, 0);
    chk("async_rst_ready_op_wait", bus.op_ready_o, 1);
    chk("async_rst_busy", bus.busy_o, 0);
    chk("async_rst_cmd", bus.eng_cmd_o, 0);
    repeat (2) @(negedge clk);
    exp_wr = exp_rd;
    rst_n = 1'b1;
    @(negedge clk);

    // Volatile config write after the interrupted erase
    give(8'h80);
    run_op(2'd3, 24'h0, 9'd0, 0, 0, 3, 0, 8'h80);

    // Flash never ready: timeout after POLL_LIMIT reads
    give(8'h00); give(8'h00); give(8'h00); give(8'h00);
    run_op(2'd1, 24'h000100, 9'd0, 0, 1, 6, 1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin : watchdog
    #600000;
    fails++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/qspi_flash_op_sequencer.md
# qspi_flash_op_sequencer

Sequences multi-step flash program and erase operations for the QSPI flash controller. It accepts one high-level operation at a time from the register block: page program, sector erase, bulk erase or volatile-config write. It expands each operation into the WREN, operation and RFSR-poll transaction sequence the flash requires. Transactions go to the QSPI transaction engine over a req/ack/done handshake. Payload data does not pass through this block; the engine sources program bytes from its own FIFO.

## Interface
- POLL_LIMIT, 65535: maximum RFSR reads per operation before timeout (>=1).
- AW, 24: flash address width.
- clk_i  in  1  controller clock.
- rst_ni  in  1  asynchronous active-low reset.
- op_valid_i  in  1  operation request.
- op_ready_o  out  1  sequencer idle and able to accept.
- op_type_i  in  2  0=PP, 1=SE, 2=BE, 3=WRVECR.
- op_addr_i  in  AW  target address (PP/SE only).
- op_len_i  in  9  PP byte count, legal range 1..256.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse: operation completed, flash ready.
- err_o  out  1  one-cycle pulse: illegal length or poll timeout.
- fsr_o  out  8  last RFSR byte read.
- eng_req_o  out  1  transaction request to engine.
- eng_cmd_o  out  8  opcode.
- eng_addr_o  out  AW  address.
- eng_has_addr_o  out  1  address phase present.
- eng_len_o  out  9  data-phase bytes (0 = none).
- eng_rd_o  out  1  data phase is read.
- eng_ack_i  in  1  engine accepted the request.
- eng_done_i  in  1  one-cycle pulse: transaction complete.
- eng_rdata_i  in  8  first read byte; valid with eng_done_i.

## Operation
- Opcodes:
  - WREN 0x06: no address, length 0.
  - PP 0x02: address, length op_len, write.
  - SE 0xD8: address, length 0.
  - BE 0xC7: no address, length 0.
  - WRVECR 0x61: no address, length 1, write.
  - RFSR 0x70: no address, length 1, read.
- States: IDLE, WREN_REQ, WREN_WAIT, OP_REQ, OP_WAIT, POLL_REQ, POLL_WAIT, DONE.
- IDLE accept path:
  - op_ready_o = (state==IDLE).
  - On op_valid_i&&op_ready_o, latch op_type, op_addr and op_len.
  - Clear the poll counter and go to WREN_REQ.
- IDLE reject path:
  - PP with op_len_i==0 or >256 is not accepted into the sequence.
  - err_o pulses in the next cycle and state stays IDLE.
  - No engine traffic is issued.
- *_REQ states:
  - eng_req_o=1 with fields held stable.
  - On eng_ack_i, go to the matching *_WAIT state; eng_req_o drops the next cycle.
- *_WAIT states: on eng_done_i, go WREN_WAIT->OP_REQ, OP_WAIT->POLL_REQ, or evaluate the poll result (POLL_WAIT).
- POLL_WAIT on eng_done_i:
  - fsr_o<=eng_rdata_i.
  - If bit7=1, go to DONE.
  - Otherwise increment the counter. If counter==POLL_LIMIT, pulse err_o and go to IDLE; else go to POLL_REQ.
- DONE: done_o=1 for one cycle, then IDLE.
- Poll counter width is $clog2(POLL_LIMIT+1) and never wraps.
- eng_done_i outside a *_WAIT state is ignored.
- The engine guarantees eng_done_i no earlier than the cycle after eng_ack_i.
- busy_o = (state!=IDLE).
- Reset mid-operation:
  - State returns to IDLE asynchronously and eng_req_o drops immediately.
  - An outstanding engine transaction is the engine's responsibility; it is reset by the same rst_ni.

## Timing
- Reset values:
  - eng_req_o, done_o, err_o and busy_o are 0.
  - fsr_o, eng_cmd_o, eng_addr_o, eng_len_o, eng_has_addr_o and eng_rd_o are 0.
  - op_ready_o is 1.
- Accept in cycle N gives eng_req_o=1 (WREN) in N+1.
- Request hand-off:
  - eng_ack_i at cycle A gives eng_req_o=0 at A+1.
  - eng_done_i at D gives the next eng_req_o at D+1.
- Completion:
  - Final ready poll done at F gives done_o at F+1 and op_ready_o at F+2.
  - Timeout poll done at F gives err_o at F+1 and op_ready_o at F+1.
- All outputs are registered except op_ready_o, which is decoded from state.

## Test plan
- PP, addr 0x012340, len 256, engine acks immediately, 3rd RFSR returns 0x80 (first two 0x00):
  - Engine sees 0x06, 0x02@0x012340 len256, then 0x70 three times.
  - done_o pulses once; fsr_o=0x80.
- BE with eng_ack_i delayed 5 cycles each:
  - eng_req_o and its fields stay stable until ack.
  - Sequence is 0x06, 0xC7 (no addr), then 0x70.
- PP with len 0 and with len 300: err_o pulses one cycle after accept, no eng_req_o, op_ready_o stays 1.
- POLL_LIMIT=4, RFSR always 0x00: exactly 4 RFSR transactions, then err_o, no done_o, IDLE.
- Async reset asserted during OP_WAIT of an SE: eng_req_o=0 and op_ready_o=1 immediately. A new WRVECR then runs 0x06, 0x61 len1, 0x70.
- Spurious eng_done_i in IDLE and during WREN_REQ: no state change, no output change.
